// File: rtl/csr_exec_unit.sv
// csr_exec_unit: executes Zicsr requests (CSRRW/S/C and immediate forms) and
// trap-entry bookkeeping against an external machine special register file.
// Optional build macro CSR_CYCLE_EN adds a free-running 64-bit cycle counter
// readable at 0xB00 (low word) and 0xB80 (high word).
module csr_exec_unit #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_valid,
  output logic              O_ready,
  input  logic [2:0]        I_funct3,
  input  logic [11:0]       I_csr_addr,
  input  logic [4:0]        I_rs1_idx,
  input  logic [DATA_W-1:0] I_rs1_data,
  input  logic              I_trap,
  input  logic [DATA_W-1:0] I_trap_pc,
  input  logic [DATA_W-1:0] I_trap_cause,
  output logic [IDX_W-1:0]  O_msr_rs,
  input  logic [DATA_W-1:0] I_msr_rdata,
  output logic [IDX_W-1:0]  O_msr_rd,
  output logic              O_msr_wen,
  output logic [DATA_W-1:0] O_msr_wdata,
  output logic              O_done,
  output logic [DATA_W-1:0] O_rd_data,
  output logic              O_illegal,
  output logic [DATA_W-1:0] O_trap_vec
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_TEPC, S_TCAUSE, S_TVEC, S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] IDX_MISA   = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_MTVEC  = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_MEPC   = IDX_W'(6);
  localparam logic [IDX_W-1:0] IDX_MCAUSE = IDX_W'(7);

  state_t state_q, state_d;

  // Latched request and trap operands (data only, not reset).
  logic [2:0]        f3_q;
  logic [11:0]       addr_q;
  logic [4:0]        rs1_idx_q;
  logic [DATA_W-1:0] rs1_data_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] cause_q;
  logic [DATA_W-1:0] old_q;

  // Result registers presented alongside O_done.
  logic [DATA_W-1:0] rd_data_q;
  logic              illegal_q;
  logic [DATA_W-1:0] trap_vec_q;

  // Decoded view of the latched request.
  logic [1:0]        op;
  logic              wr_req;
  logic              illegal;
  logic              is_ctr;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] ctr_val;
  logic [DATA_W-1:0] rdval;
  logic [DATA_W-1:0] new_val;

  function automatic logic [IDX_W-1:0] map_idx(input logic [11:0] a);
    case (a)
      12'h300: map_idx = IDX_W'(1);
      12'h301: map_idx = IDX_W'(2);
      12'h304: map_idx = IDX_W'(3);
      12'h305: map_idx = IDX_W'(4);
      12'h340: map_idx = IDX_W'(5);
      12'h341: map_idx = IDX_W'(6);
      12'h342: map_idx = IDX_W'(7);
      12'h343: map_idx = IDX_W'(8);
      12'h344: map_idx = IDX_W'(9);
      default: map_idx = '0;
    endcase
  endfunction

`ifdef CSR_CYCLE_EN
  logic [63:0] cnt_q;

  // Free-running cycle counter.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) cnt_q <= '0;
    else       cnt_q <= cnt_q + 64'd1;
  end

  assign is_ctr  = (addr_q == 12'hB00) || (addr_q == 12'hB80);
  assign ctr_val = (addr_q == 12'hB80) ? DATA_W'(cnt_q[63:32]) : DATA_W'(cnt_q[31:0]);
`else
  assign is_ctr  = 1'b0;
  assign ctr_val = '0;
`endif

  // Decode the latched request: operand source, write need, legality, new value.
  always_comb begin
    op      = f3_q[1:0];
    idx     = map_idx(addr_q);
    src     = f3_q[2] ? DATA_W'(rs1_idx_q) : rs1_data_q;
    wr_req  = (op == 2'b01) || (rs1_idx_q != 5'd0);
    illegal = (op == 2'b00) || ((idx == '0) && !is_ctr) ||
              (wr_req && ((idx == IDX_MISA) || is_ctr));
    rdval   = is_ctr ? ctr_val : I_msr_rdata;
    case (op)
      2'b01:   new_val = src;
      2'b10:   new_val = old_q | src;
      2'b11:   new_val = old_q & ~src;
      default: new_val = old_q;
    endcase
  end

  // State register.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and msr port drive.
  always_comb begin
    state_d     = state_q;
    O_ready     = 1'b0;
    O_msr_rs    = '0;
    O_msr_rd    = '0;
    O_msr_wen   = 1'b0;
    O_msr_wdata = '0;
    O_done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        O_ready = !I_trap;
        if (I_trap)       state_d = S_TEPC;
        else if (I_valid) state_d = S_READ;
      end
      S_READ: begin
        O_msr_rs = idx;
        state_d  = (wr_req && !illegal) ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        O_msr_wen   = 1'b1;
        O_msr_rd    = idx;
        O_msr_wdata = new_val;
        state_d     = S_DONE;
      end
      S_TEPC: begin
        O_msr_wen   = 1'b1;
        O_msr_rd    = IDX_MEPC;
        O_msr_wdata = pc_q;
        state_d     = S_TCAUSE;
      end
      S_TCAUSE: begin
        O_msr_wen   = 1'b1;
        O_msr_rd    = IDX_MCAUSE;
        O_msr_wdata = cause_q;
        state_d     = S_TVEC;
      end
      S_TVEC: begin
        O_msr_rs = IDX_MTVEC;
        state_d  = S_DONE;
      end
      S_DONE: begin
        O_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture request or trap operands while idle; trap wins over a request.
  always_ff @(posedge I_clk) begin
    if (state_q == S_IDLE) begin
      if (I_trap) begin
        pc_q    <= I_trap_pc;
        cause_q <= I_trap_cause;
      end else if (I_valid) begin
        f3_q       <= I_funct3;
        addr_q     <= I_csr_addr;
        rs1_idx_q  <= I_rs1_idx;
        rs1_data_q <= I_rs1_data;
      end
    end
  end

  // Snapshot the old CSR value during READ for the read-modify-write.
  always_ff @(posedge I_clk) begin
    if (state_q == S_READ) old_q <= rdval;
  end

  // Result registers update on entry to DONE and hold until the next DONE.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      rd_data_q  <= '0;
      illegal_q  <= 1'b0;
      trap_vec_q <= '0;
    end else begin
      case (state_q)
        S_READ: begin
          if (!(wr_req && !illegal)) begin
            rd_data_q <= illegal ? '0 : rdval;
            illegal_q <= illegal;
          end
        end
        S_WRITE: begin
          rd_data_q <= old_q;
          illegal_q <= 1'b0;
        end
        S_TVEC:  trap_vec_q <= I_msr_rdata & ~DATA_W'(3);
        default: ;
      endcase
    end
  end

  assign O_rd_data  = rd_data_q;
  assign O_illegal  = illegal_q;
  assign O_trap_vec = trap_vec_q;

endmodule
